// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side handshake and fields, MEM-side handshake and fields,
// flush and the stall counter readout. The stage itself uses the slave modport.
interface ex_mem_stage_if #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 16
);
  logic                      flush;

  logic                      in_valid;
  logic                      in_ready;
  logic [REG_WIDTH-1:0]      in_alu_out;
  logic [REG_WIDTH-1:0]      in_dataB;
  logic [6:0]                in_opcode;
  logic [REG_ADDR_WIDTH-1:0] in_rs1;
  logic [REG_ADDR_WIDTH-1:0] in_rs2;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      in_reg_write_en;
  logic                      in_mem_write_en;
  logic                      in_wb_sel;
  logic [PC_WIDTH-1:0]       in_pc_next;

  logic                      out_valid;
  logic                      out_ready;
  logic [REG_WIDTH-1:0]      out_alu_out;
  logic [REG_WIDTH-1:0]      out_dataB;
  logic [6:0]                out_opcode;
  logic [REG_ADDR_WIDTH-1:0] out_rs1;
  logic [REG_ADDR_WIDTH-1:0] out_rs2;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_reg_write_en;
  logic                      out_mem_write_en;
  logic                      out_wb_sel;

  logic [CNT_WIDTH-1:0]      stall_cnt;

  modport master (
    output flush, in_valid, in_alu_out, in_dataB, in_opcode, in_rs1, in_rs2, in_rd,
           in_reg_write_en, in_mem_write_en, in_wb_sel, in_pc_next, out_ready,
    input  in_ready, out_valid, out_alu_out, out_dataB, out_opcode, out_rs1, out_rs2,
           out_rd, out_reg_write_en, out_mem_write_en, out_wb_sel, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_alu_out, in_dataB, in_opcode, in_rs1, in_rs2, in_rd,
           in_reg_write_en, in_mem_write_en, in_wb_sel, in_pc_next, out_ready,
    output in_ready, out_valid, out_alu_out, out_dataB, out_opcode, out_rs1, out_rs2,
           out_rd, out_reg_write_en, out_mem_write_en, out_wb_sel, stall_cnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// Entry M drives the MEM side; entry S absorbs one instruction while M is stalled,
// so in_ready can come straight from a flop. JAL/JALR link value replaces the ALU
// result at capture. stall_cnt saturates and is cleared only by reset.
module ex_mem_stage #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_stage_if.slave bus
);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [REG_WIDTH-1:0]      result;
    logic [REG_WIDTH-1:0]      data_b;
    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_we;
    logic                      mem_we;
    logic                      wb_sel;
  } entry_t;

  entry_t               m_q;
  entry_t               s_q;
  entry_t               cap;
  logic                 m_valid;
  logic                 s_valid;
  logic                 accept;
  logic                 drain;
  logic [REG_WIDTH-1:0] link_value;
  logic [CNT_WIDTH-1:0] stall_q;

  // Link value is PC+4 fitted to the register width (zero-extend or truncate).
  generate
    if (PC_WIDTH >= REG_WIDTH) begin : g_link_trunc
      assign link_value = bus.in_pc_next[REG_WIDTH-1:0];
    end else begin : g_link_ext
      assign link_value = {{(REG_WIDTH-PC_WIDTH){1'b0}}, bus.in_pc_next};
    end
  endgenerate

  assign accept = bus.in_valid & ~s_valid;
  assign drain  = m_valid & bus.out_ready;

  // Build the entry to be stored, applying the JAL/JALR result substitution.
  always_comb begin
    cap        = '0;
    cap.result = ((bus.in_opcode == OP_JAL) || (bus.in_opcode == OP_JALR)) ?
                 link_value : bus.in_alu_out;
    cap.data_b = bus.in_dataB;
    cap.opcode = bus.in_opcode;
    cap.rs1    = bus.in_rs1;
    cap.rs2    = bus.in_rs2;
    cap.rd     = bus.in_rd;
    cap.reg_we = bus.in_reg_write_en;
    cap.mem_we = bus.in_mem_write_en;
    cap.wb_sel = bus.in_wb_sel;
  end

  // Skid buffer update: S always refills M first so order is preserved; flush wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || drain) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        if (accept) begin
          s_q     <= cap;
          s_valid <= 1'b1;
        end else begin
          s_valid <= 1'b0;
        end
      end else if (accept) begin
        m_q     <= cap;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_q     <= cap;
      s_valid <= 1'b1;
    end
  end

  // Count cycles where MEM holds a valid entry but refuses it; stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (m_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.in_ready         = ~s_valid;
  assign bus.out_valid        = m_valid;
  assign bus.out_alu_out      = m_q.result;
  assign bus.out_dataB        = m_q.data_b;
  assign bus.out_opcode       = m_q.opcode;
  assign bus.out_rs1          = m_q.rs1;
  assign bus.out_rs2          = m_q.rs2;
  assign bus.out_rd           = m_q.rd;
  assign bus.out_reg_write_en = m_q.reg_we & m_valid;
  assign bus.out_mem_write_en = m_q.mem_we & m_valid;
  assign bus.out_wb_sel       = m_q.wb_sel;
  assign bus.stall_cnt        = stall_q;

endmodule
